// File: rtl/seq_det_mealy_1011.sv
// Serial 1-0-1-1 pattern detector, four-state Mealy machine.
// The detect output is combinational from the state register and the live input bit.
module seq_det_mealy_1011 #(
    parameter int OVERLAP = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic x,
    output logic y
);

    typedef enum logic [1:0] {
        S0   = 2'b00,
        S1   = 2'b01,
        S10  = 2'b10,
        S101 = 2'b11
    } state_t;

    // After a match, overlapping mode keeps the trailing "1" as a fresh prefix.
    localparam state_t MATCH_NEXT = (OVERLAP != 0) ? S1 : S0;

    state_t r_state;
    state_t w_next_state;
    logic   w_detect;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S0;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = S0;
        w_detect     = 1'b0;
        case (r_state)
            S0: begin
                w_next_state = x ? S1 : S0;
            end
            S1: begin
                w_next_state = x ? S1 : S10;
            end
            S10: begin
                w_next_state = x ? S101 : S0;
            end
            S101: begin
                w_next_state = x ? MATCH_NEXT : S10;
                w_detect     = x;
            end
            default: begin
                w_next_state = S0;
                w_detect     = 1'b0;
            end
        endcase
    end

    assign y = w_detect & ~rst;

endmodule

// File: tb/tb_seq_det_mealy_1011.sv
// Vector bench driving overlapping and non-overlapping detectors from one stimulus stream.
module tb_seq_det_mealy_1011;

    typedef struct {
        logic rst;
        logic x;
        logic exp_y_ov;
        logic exp_y_nov;
    } vec_t;

    logic clk;
    logic rst;
    logic x;
    logic y_ov;
    logic y_nov;

    vec_t vecs[$];
    int   n_vec;
    int   n_err;

    seq_det_mealy_1011 #(.OVERLAP(1)) u_dut_ov (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .y   (y_ov)
    );

    seq_det_mealy_1011 #(.OVERLAP(0)) u_dut_nov (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .y   (y_nov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add_rst(input logic xv);
        vec_t v;
        v.rst       = 1'b1;
        v.x         = xv;
        v.exp_y_ov  = 1'b0;
        v.exp_y_nov = 1'b0;
        vecs.push_back(v);
    endtask

    // One character per cycle: x stream, expected y for OVERLAP=1, expected y for OVERLAP=0.
    task automatic add_seq(input string xs, input string e_ov, input string e_nov);
        vec_t v;
        for (int i = 0; i < xs.len(); i++) begin
            v.rst       = 1'b0;
            v.x         = (xs[i] == "1");
            v.exp_y_ov  = (e_ov[i] == "1");
            v.exp_y_nov = (e_nov[i] == "1");
            vecs.push_back(v);
        end
    endtask

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: y_ov,y_nov = %b, expected %b", name, act, exp);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        x     = 1'b0;

        // Reset held while the full pattern is presented, then x=1,0,1,1 from S0.
        add_rst(1'b1); add_rst(1'b0); add_rst(1'b1); add_rst(1'b1);
        add_seq("1011", "0001", "0001");
        // Basic detect.
        add_rst(1'b0);
        add_seq("1011", "0001", "0001");
        // Overlap versus restart.
        add_rst(1'b0);
        add_seq("1011011", "0001001", "0001000");
        // Back-to-back non-overlapping matches, 4 cycles apart.
        add_rst(1'b0);
        add_seq("10111011", "00010001", "00010001");
        // Prefix recovery paths.
        add_rst(1'b0);
        add_seq("11011", "00001", "00001");
        add_rst(1'b0);
        add_seq("101011", "000001", "000001");
        add_rst(1'b0);
        add_seq("1001011", "0000001", "0000001");
        // Reset mid-pattern: in S101 with x=1, reset must mask y and discard the prefix.
        add_rst(1'b0);
        add_seq("101", "000", "000");
        add_rst(1'b1);
        add_seq("1011", "0001", "0001");

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst;
            x   = vecs[i].x;
            #1;
            check($sformatf("vec%0d", i), {y_ov, y_nov},
                  {vecs[i].exp_y_ov, vecs[i].exp_y_nov});
        end

        // Combinational path: sit in S101 and wiggle x without a clock edge.
        @(negedge clk); rst = 1'b1; x = 1'b0;
        @(negedge clk); rst = 1'b0; x = 1'b1;
        @(negedge clk); x = 1'b0;
        @(negedge clk); x = 1'b1;
        @(negedge clk); x = 1'b0;
        #1 check("mealy_x0_a", {y_ov, y_nov}, 2'b00);
        x = 1'b1;
        #1 check("mealy_x1", {y_ov, y_nov}, 2'b11);
        x = 1'b0;
        #1 check("mealy_x0_b", {y_ov, y_nov}, 2'b00);
        x = 1'b1;
        #1 check("mealy_x1_b", {y_ov, y_nov}, 2'b11);
        rst = 1'b1;
        #1 check("mealy_rst_mask", {y_ov, y_nov}, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
